// File: rtl/baud_rate_gen_if.sv
// Control/status bundle between a UART timing user (master) and baud_rate_gen (slave).
// dvsr_frac is present only when BAUD_FRAC_EN is defined.
interface baud_rate_gen_if #(
  parameter int N   = 11,
  parameter int OVS = 16,
  parameter int FW  = 4
);
  localparam int OW = $clog2(OVS);

  logic          en;
  logic          clr;
  logic [N-1:0]  dvsr;
  logic          dvsr_ld;
`ifdef BAUD_FRAC_EN
  logic [FW-1:0] dvsr_frac;
`endif
  logic          s_tick;
  logic          b_tick;
  logic [N-1:0]  q;
  logic [OW-1:0] os_cnt;

  modport master (
`ifdef BAUD_FRAC_EN
    output dvsr_frac,
`endif
    output en, clr, dvsr, dvsr_ld,
    input  s_tick, b_tick, q, os_cnt
  );

  modport slave (
`ifdef BAUD_FRAC_EN
    input  dvsr_frac,
`endif
    input  en, clr, dvsr, dvsr_ld,
    output s_tick, b_tick, q, os_cnt
  );
endinterface

// File: rtl/baud_rate_gen.sv
// Programmable oversampling/bit tick generator with glitch-free divisor reload.
// Optional fractional divisor enabled by defining BAUD_FRAC_EN.
module baud_rate_gen #(
  parameter int N        = 11,
  parameter int OVS      = 16,
  parameter int DVSR_RST = 650,
  parameter int FW       = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  baud_rate_gen_if.slave    bus
);
  localparam int            OW        = $clog2(OVS);
  localparam logic [OW-1:0] OS_LAST   = OW'(OVS - 1);
  localparam logic [N-1:0]  DVSR_INIT = N'(DVSR_RST);

  if (OVS < 2 || FW < 1) begin : g_param_chk
    $error("baud_rate_gen: OVS must be >= 2 and FW >= 1");
  end

  logic [N-1:0]  q_q, q_d;
  logic [OW-1:0] os_q, os_d;
  logic          s_tick_q, s_tick_d;
  logic          b_tick_q, b_tick_d;
  logic [N-1:0]  dvsr_act_q, dvsr_act_d;
  logic [N-1:0]  pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic          carry;
  logic [N:0]    term;
  logic          wrap;
  logic          apply;

`ifdef BAUD_FRAC_EN
  logic [FW-1:0] acc_q, acc_d;
  logic [FW-1:0] frac_act_q, frac_act_d;
  logic [FW-1:0] frac_pend_q, frac_pend_d;
  logic [FW:0]   acc_sum;

  // Carry out of the running fraction stretches the current period by one cycle.
  assign acc_sum = {1'b0, acc_q} + {1'b0, frac_act_q};
  assign carry   = acc_sum[FW];
`else
  assign carry   = 1'b0;
`endif

  // >= rather than == so a divisor reduced below q still terminates the period.
  assign term  = {1'b0, dvsr_act_q} + (N+1)'(carry);
  assign wrap  = bus.en && !bus.clr && ({1'b0, q_q} >= term);
  assign apply = bus.clr || !bus.en || wrap;

  always_comb begin
    q_d        = q_q;
    os_d       = os_q;
    s_tick_d   = 1'b0;
    b_tick_d   = 1'b0;
    dvsr_act_d = dvsr_act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;

    if (bus.clr) begin
      q_d  = '0;
      os_d = '0;
    end else if (wrap) begin
      q_d      = '0;
      s_tick_d = 1'b1;
      b_tick_d = (os_q == OS_LAST);
      os_d     = (os_q == OS_LAST) ? '0 : os_q + OW'(1);
    end else if (bus.en) begin
      q_d = q_q + N'(1);
    end

    // A load coinciding with a period boundary bypasses the pending register.
    if (bus.dvsr_ld) begin
      pend_d = bus.dvsr;
      if (apply) begin
        dvsr_act_d = bus.dvsr;
        pend_vld_d = 1'b0;
      end else begin
        pend_vld_d = 1'b1;
      end
    end else if (apply && pend_vld_q) begin
      dvsr_act_d = pend_q;
      pend_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q        <= '0;
      os_q       <= '0;
      s_tick_q   <= 1'b0;
      b_tick_q   <= 1'b0;
      dvsr_act_q <= DVSR_INIT;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      os_q       <= os_d;
      s_tick_q   <= s_tick_d;
      b_tick_q   <= b_tick_d;
      dvsr_act_q <= dvsr_act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

`ifdef BAUD_FRAC_EN
  // Fraction travels with the integer divisor through the same pending/apply path.
  always_comb begin
    acc_d       = acc_q;
    frac_act_d  = frac_act_q;
    frac_pend_d = frac_pend_q;

    if (bus.clr) begin
      acc_d = '0;
    end else if (wrap) begin
      acc_d = acc_sum[FW-1:0];
    end

    if (bus.dvsr_ld) begin
      frac_pend_d = bus.dvsr_frac;
      if (apply) begin
        frac_act_d = bus.dvsr_frac;
      end
    end else if (apply && pend_vld_q) begin
      frac_act_d = frac_pend_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= '0;
      frac_act_q  <= '0;
      frac_pend_q <= '0;
    end else begin
      acc_q       <= acc_d;
      frac_act_q  <= frac_act_d;
      frac_pend_q <= frac_pend_d;
    end
  end
`endif

  assign bus.q      = q_q;
  assign bus.os_cnt = os_q;
  assign bus.s_tick = s_tick_q;
  assign bus.b_tick = b_tick_q;
endmodule

// File: tb/tb_baud_rate_gen.sv
// Self-checking bench for baud_rate_gen: period-level reference model compared every cycle,
// plus directed timing checks with hand-computed cycle numbers.
module tb_baud_rate_gen;
  localparam int N        = 11;
  localparam int OVS      = 16;
  localparam int DVSR_RST = 650;
  localparam int FW       = 4;
  localparam int FRAC_MOD = 16;

  logic clk;
  logic resetN;
  int   checkCount;
  int   errorCount;
  int   cycleNo;

  baud_rate_gen_if #(.N(N), .OVS(OVS), .FW(FW)) bus ();

  baud_rate_gen #(.N(N), .OVS(OVS), .DVSR_RST(DVSR_RST), .FW(FW)) dut (
    .clk     (clk),
    .reset_n (resetN),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: tracks cycles elapsed in the current period and total ticks issued.
  int mD, mPend, mFracAct, mFracPend, mPos, mTicks, mAcc;
  bit mPendVld, mS, mB;

  function automatic void modelReset();
    mD = DVSR_RST; mPend = 0; mPendVld = 1'b0; mFracAct = 0; mFracPend = 0;
    mPos = 0; mTicks = 0; mAcc = 0; mS = 1'b0; mB = 1'b0;
  endfunction

  function automatic void modelStep();
    int  frac;
    int  periodLen;
    bit  ends;
    bit  boundary;
    frac = 0;
`ifdef BAUD_FRAC_EN
    frac = int'(bus.dvsr_frac);
`endif
    if (!resetN) begin
      modelReset();
      return;
    end
    periodLen = mD + 1 + (((mAcc + mFracAct) >= FRAC_MOD) ? 1 : 0);
    ends      = bus.en && !bus.clr && ((mPos + 1) >= periodLen);
    boundary  = bus.clr || !bus.en || ends;
    mS = 1'b0;
    mB = 1'b0;
    if (bus.clr) begin
      mPos = 0; mTicks = 0; mAcc = 0;
    end else if (ends) begin
      mPos   = 0;
      mTicks = mTicks + 1;
      mS     = 1'b1;
      mB     = ((mTicks % OVS) == 0);
      mAcc   = (mAcc + mFracAct) % FRAC_MOD;
    end else if (bus.en) begin
      mPos = mPos + 1;
    end
    if (bus.dvsr_ld) begin
      mPend = int'(bus.dvsr); mFracPend = frac;
      if (boundary) begin
        mD = int'(bus.dvsr); mFracAct = frac; mPendVld = 1'b0;
      end else begin
        mPendVld = 1'b1;
      end
    end else if (boundary && mPendVld) begin
      mD = mPend; mFracAct = mFracPend; mPendVld = 1'b0;
    end
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount = checkCount + 1;
    if (actual != expected) begin
      errorCount = errorCount + 1;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("s_tick", int'(bus.s_tick), int'(mS));
    checkOutput("b_tick", int'(bus.b_tick), int'(mB));
    checkOutput("q", int'(bus.q), mPos);
    checkOutput("os_cnt", int'(bus.os_cnt), mTicks % OVS);
  end

  task automatic applyStimulus(input bit en, input bit clr, input int dvsr, input bit ld, input int frac);
    bus.en      = en;
    bus.clr     = clr;
    bus.dvsr    = N'(dvsr);
    bus.dvsr_ld = ld;
`ifdef BAUD_FRAC_EN
    bus.dvsr_frac = FW'(frac);
`else
    if (frac != 0) $display("[TB] note: fractional divisor ignored in integer build");
`endif
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelStep();
    #1;
    cycleNo = cycleNo + 1;
  endtask

  task automatic waitTick(input bit wantB, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      stepCycle();
      if ((wantB ? bus.b_tick : bus.s_tick) == 1'b1) begin
        at = cycleNo;
        break;
      end
    end
    if (at < 0) checkOutput(wantB ? "b_tick_timeout" : "s_tick_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t1, t2, t3, t4, b1, b2, c0, bCount, allS, maxQ;
    checkCount = 0;
    errorCount = 0;
    cycleNo    = 0;
    resetN     = 1'b0;
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);
    modelReset();
    repeat (3) stepCycle();
    checkOutput("rst_q", int'(bus.q), 0);
    checkOutput("rst_os", int'(bus.os_cnt), 0);
    checkOutput("rst_s", int'(bus.s_tick), 0);
    checkOutput("rst_b", int'(bus.b_tick), 0);

    // Default divisor from reset release.
    resetN = 1'b1;
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 0);
    cycleNo = 0;
    waitTick(1'b0, 700, t1);
    checkOutput("first_s_cycle", t1, 651);
    waitTick(1'b0, 700, t2);
    checkOutput("s_period_651", t2 - t1, 651);
    waitTick(1'b1, 11000, b1);
    checkOutput("first_b_cycle", b1, 10416);
    checkOutput("os_after_b", int'(bus.os_cnt), 0);
    checkOutput("s_with_b", int'(bus.s_tick), 1);

    // Load while disabled applies at once.
    applyStimulus(1'b0, 1'b0, 4, 1'b1, 0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 4, 1'b0, 0);
    waitTick(1'b0, 20, t1);
    waitTick(1'b0, 20, t2);
    checkOutput("s_period_5", t2 - t1, 5);
    waitTick(1'b1, 100, b1);
    waitTick(1'b1, 100, b2);
    checkOutput("b_period_80", b2 - b1, 80);
    checkOutput("s_with_b80", int'(bus.s_tick), 1);

    // Mid-period load is deferred to the boundary.
    waitTick(1'b0, 20, t1);
    stepCycle();
    stepCycle();
    checkOutput("q_mid", int'(bus.q), 2);
    applyStimulus(1'b1, 1'b0, 9, 1'b1, 0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 9, 1'b0, 0);
    waitTick(1'b0, 20, t2);
    checkOutput("deferred_end", t2 - t1, 5);
    waitTick(1'b0, 20, t3);
    checkOutput("new_period_10a", t3 - t2, 10);
    waitTick(1'b0, 20, t4);
    checkOutput("new_period_10b", t4 - t3, 10);

    // Divisor zero: tick every cycle.
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 0);
    stepCycle();
    bCount = 0; allS = 1; maxQ = 0;
    for (int i = 0; i < 32; i++) begin
      stepCycle();
      if (bus.s_tick != 1'b1) allS = 0;
      if (bus.b_tick == 1'b1) bCount = bCount + 1;
      if (int'(bus.q) > maxQ) maxQ = int'(bus.q);
    end
    checkOutput("dvsr0_s_const", allS, 1);
    checkOutput("dvsr0_b_count", bCount, 2);
    checkOutput("dvsr0_q_max", maxQ, 0);

    // Synchronous clear mid-period.
    applyStimulus(1'b0, 1'b0, 4, 1'b1, 0);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 4, 1'b0, 0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 4, 1'b0, 0);
    repeat (38) stepCycle();
    checkOutput("pre_clr_q", int'(bus.q), 3);
    checkOutput("pre_clr_os", int'(bus.os_cnt), 7);
    applyStimulus(1'b1, 1'b1, 4, 1'b0, 0);
    stepCycle();
    checkOutput("clr_q", int'(bus.q), 0);
    checkOutput("clr_os", int'(bus.os_cnt), 0);
    checkOutput("clr_s", int'(bus.s_tick), 0);
    applyStimulus(1'b1, 1'b0, 4, 1'b0, 0);
    c0 = cycleNo;
    waitTick(1'b0, 20, t1);
    checkOutput("clr_to_tick", t1 - c0, 5);

    // Async reset with a pending load outstanding.
    applyStimulus(1'b1, 1'b0, 9, 1'b1, 0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 9, 1'b0, 0);
    stepCycle();
    resetN = 1'b0;
    modelReset();
    #1;
    checkOutput("arst_q", int'(bus.q), 0);
    checkOutput("arst_s", int'(bus.s_tick), 0);
    checkOutput("arst_b", int'(bus.b_tick), 0);
    repeat (2) stepCycle();
    resetN = 1'b1;
    cycleNo = 0;
    waitTick(1'b0, 700, t1);
    checkOutput("post_rst_first_s", t1, 651);

`ifdef BAUD_FRAC_EN
    // Half-cycle fraction: periods alternate 5 and 6.
    applyStimulus(1'b0, 1'b0, 4, 1'b1, 8);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 4, 1'b0, 8);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 4, 1'b0, 8);
    c0 = cycleNo;
    waitTick(1'b0, 20, t1);
    checkOutput("frac_p1", t1 - c0, 5);
    waitTick(1'b0, 20, t2);
    checkOutput("frac_p2", t2 - t1, 6);
    waitTick(1'b1, 120, b1);
    checkOutput("frac_b_cycle", b1 - c0, 88);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule

// File: doc/baud_rate_gen.md
Name: baud_rate_gen

Overview:
- Programmable tick generator for the UART path; next generation of the fixed mod-M tick counter.
- Produces an oversampling tick (`s_tick`) and a bit tick (`b_tick`, every OVS sample ticks).
- Divisor is loadable at run time; changes are glitch-free because a new divisor only takes effect at a period boundary.
- Has enable and synchronous clear; feeds the UART rx/tx sampling FSMs.

Parameters:
- N, 11, counter/divisor width in bits.
- OVS, 16, oversampling factor (s_ticks per b_tick), >=2.
- DVSR_RST, 650, divisor terminal count after reset (100 MHz / (16*9600) - 1).
- FW, 4, fractional divisor width; used only with BAUD_FRAC_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  count enable; counters hold when 0.
- clr  in  1  synchronous clear of counters/ticks; priority over en.
- dvsr  in  N  new terminal count; tick period = dvsr+1 cycles.
- dvsr_ld  in  1  one-cycle strobe capturing dvsr into the pending register.
- dvsr_frac  in  FW  fractional divisor part; present only with BAUD_FRAC_EN.
- s_tick  out  1  registered one-cycle oversampling tick.
- b_tick  out  1  registered one-cycle bit tick, coincident with every OVS-th s_tick.
- q  out  N  current sample counter value.
- os_cnt  out  $clog2(OVS)  current oversample index, 0..OVS-1.

Behaviour:
- Reset (async, reset_n=0):
  - q=0, os_cnt=0, s_tick=0, b_tick=0.
  - dvsr_act=DVSR_RST, pend=0, pend_vld=0, frac accumulator=0.
- Divisor load:
  - dvsr_ld=1 captures dvsr (and dvsr_frac) into pend and sets pend_vld=1.
  - A later dvsr_ld before the apply event overwrites pend; last write wins.
- Apply event is any of: (en=1 and q>=dvsr_act), clr=1, or en=0.
  - On an apply event with pend_vld=1: dvsr_act<=pend, pend_vld<=0.
  - dvsr_ld in the same cycle as an apply event: the dvsr input is applied directly and pend_vld ends 0.
- Counter:
  - clr=1: q<=0, os_cnt<=0, s_tick<=0, b_tick<=0, frac acc<=0.
  - else en=1 and q>=dvsr_act: q<=0 (wrap); s_tick<=1 next cycle. The >= compare guards q being above a reduced divisor.
  - else en=1: q<=q+1, s_tick<=0.
  - else (en=0): q holds, s_tick<=0, b_tick<=0.
- Oversample counter:
  - Each wrap advances os_cnt; OVS-1 -> 0 also sets b_tick<=1.
  - b_tick therefore pulses in the same cycle as s_tick, once per OVS wraps.
- Latency and timing with dvsr_act=D, en=1 from reset release (cycle 0):
  - First s_tick in cycle D+1, period D+1.
  - First b_tick in cycle OVS*(D+1), period OVS*(D+1).
- dvsr_act=0: wrap every cycle, s_tick high continuously from cycle 1; b_tick every OVS cycles.
- Width: q compare and increment are N-bit unsigned; q never exceeds dvsr_act+1 (+1 only with frac carry).
- Reset mid-operation: immediate return to reset values; a pending load is discarded.

Optional Feature:
- Macro BAUD_FRAC_EN.
- Defined:
  - dvsr_frac port exists, loaded and applied together with dvsr (into frac_act).
  - At each wrap, FW-bit accumulator acc<=acc+frac_act; the carry-out extends the next period by one cycle (terminal count dvsr_act+carry).
  - Average period = dvsr_act+1+frac_act/2^FW; clr and reset zero acc.
- Undefined: no dvsr_frac port, no accumulator; integer divisor only, behaviour exactly as above.

Test Plan:
- Reset release, en=1, defaults -> first s_tick cycle 651, period 651; b_tick period 10416 with os_cnt=0 after the pulse.
- en=0, dvsr=4, dvsr_ld=1 (applies immediately), then en=1 -> s_tick period 5; b_tick every 80 cycles, coincident with s_tick.
- dvsr_act=4, q=2, dvsr_ld with dvsr=9 -> current period still ends on q=4 (tick after 5 cycles); following periods 10 cycles; pend_vld clears at that wrap.
- dvsr=0 loaded, en=1 -> s_tick high every cycle; b_tick pulses once per 16 cycles; q stays 0.
- q=3, os_cnt=7, clr=1 for one cycle -> next cycle q=0, os_cnt=0, no tick; next s_tick D+1 cycles after clr deasserts. Separately, reset_n=0 mid-period -> q=0, ticks 0, dvsr_act=650 immediately.
- BAUD_FRAC_EN, dvsr=4, dvsr_frac=8 (FW=4) -> s_tick periods alternate 5,6; 16 s_ticks span 88 cycles; b_tick at cycle 88.
